// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: shadows the EX/MEM destination state to produce
// the load-use stall, the rs/rt forward selects and a saturating stall counter.
module hazard_scoreboard #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     idValid,
    input  logic [4:0]               idRs,
    input  logic [4:0]               idRt,
    input  logic                     idUsesRs,
    input  logic                     idUsesRt,
    input  logic                     idShouldWriteRegister,
    input  logic [4:0]               idRegisterWriteAddress,
    input  logic                     idIsLoad,
    input  logic                     flush,
    output logic                     shouldStall,
    output logic [1:0]               registerRsForwardControl,
    output logic [1:0]               registerRtForwardControl,
    output logic [COUNTER_WIDTH-1:0] stallCount
);

    logic                     r_ex_valid;
    logic                     r_ex_write;
    logic [4:0]               r_ex_dest;
    logic                     r_ex_load;
    logic                     r_mem_valid;
    logic                     r_mem_write;
    logic [4:0]               r_mem_dest;
    logic                     r_mem_load;
    logic [COUNTER_WIDTH-1:0] r_stall_count;

    logic w_rs_live;
    logic w_rt_live;
    logic w_rs_ex_hit;
    logic w_rt_ex_hit;
    logic w_rs_mem_hit;
    logic w_rt_mem_hit;
    logic w_bubble;

    // EX-over-MEM priority; an EX load hit stalls, so its select is left at 00.
    function automatic logic [1:0] fwd_select(
        input logic live,
        input logic ex_hit,
        input logic ex_load,
        input logic mem_hit,
        input logic mem_load
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (!live) begin
            sel = 2'b00;
        end else if (ex_hit) begin
            sel = ex_load ? 2'b00 : 2'b01;
        end else if (mem_hit) begin
            sel = mem_load ? 2'b11 : 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Source liveness, entry matches and the resulting stall/select outputs.
    always_comb begin
        w_rs_live    = idUsesRs & idValid & (idRs != 5'd0);
        w_rt_live    = idUsesRt & idValid & (idRt != 5'd0);
        w_rs_ex_hit  = r_ex_valid  & r_ex_write  & (r_ex_dest  == idRs);
        w_rt_ex_hit  = r_ex_valid  & r_ex_write  & (r_ex_dest  == idRt);
        w_rs_mem_hit = r_mem_valid & r_mem_write & (r_mem_dest == idRs);
        w_rt_mem_hit = r_mem_valid & r_mem_write & (r_mem_dest == idRt);
        shouldStall  = (w_rs_live & w_rs_ex_hit & r_ex_load) |
                       (w_rt_live & w_rt_ex_hit & r_ex_load);
        w_bubble     = shouldStall | flush | ~idValid;
        registerRsForwardControl = fwd_select(w_rs_live, w_rs_ex_hit, r_ex_load,
                                              w_rs_mem_hit, r_mem_load);
        registerRtForwardControl = fwd_select(w_rt_live, w_rt_ex_hit, r_ex_load,
                                              w_rt_mem_hit, r_mem_load);
    end

    // Advance the shadow pipeline and count stall cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_write    <= 1'b0;
            r_ex_dest     <= 5'd0;
            r_ex_load     <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_dest    <= 5'd0;
            r_mem_load    <= 1'b0;
            r_stall_count <= {COUNTER_WIDTH{1'b0}};
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_write <= r_ex_write;
            r_mem_dest  <= r_ex_dest;
            r_mem_load  <= r_ex_load;
            if (w_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_write <= 1'b0;
                r_ex_dest  <= 5'd0;
                r_ex_load  <= 1'b0;
            end else begin
                r_ex_valid <= 1'b1;
                r_ex_write <= idShouldWriteRegister;
                r_ex_dest  <= idRegisterWriteAddress;
                r_ex_load  <= idIsLoad;
            end
            if (shouldStall && (r_stall_count != {COUNTER_WIDTH{1'b1}})) begin
                r_stall_count <= r_stall_count + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

    assign stallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: an in-flight history model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_hazard_scoreboard;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          idValid = 1'b0;
    logic [4:0]    idRs = 5'd0;
    logic [4:0]    idRt = 5'd0;
    logic          idUsesRs = 1'b0;
    logic          idUsesRt = 1'b0;
    logic          idShouldWriteRegister = 1'b0;
    logic [4:0]    idRegisterWriteAddress = 5'd0;
    logic          idIsLoad = 1'b0;
    logic          flush = 1'b0;
    logic          shouldStall;
    logic [1:0]    registerRsForwardControl;
    logic [1:0]    registerRtForwardControl;
    logic [CW-1:0] stallCount;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_scoreboard #(.COUNTER_WIDTH(CW)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .idValid                 (idValid),
        .idRs                    (idRs),
        .idRt                    (idRt),
        .idUsesRs                (idUsesRs),
        .idUsesRt                (idUsesRt),
        .idShouldWriteRegister   (idShouldWriteRegister),
        .idRegisterWriteAddress  (idRegisterWriteAddress),
        .idIsLoad                (idIsLoad),
        .flush                   (flush),
        .shouldStall             (shouldStall),
        .registerRsForwardControl(registerRsForwardControl),
        .registerRtForwardControl(registerRtForwardControl),
        .stallCount              (stallCount)
    );

    always #5 clock = ~clock;

    // In-flight history, youngest first: index 0 is EX, index 1 is MEM.
    typedef struct packed {
        logic       wr;
        logic [4:0] dest;
        logic       load;
    } entry_t;

    entry_t hist[$];
    int     exp_count = 0;

    // Returns {stall, sel} for one source by searching the history youngest first.
    function automatic logic [2:0] model_src(input logic uses, input logic [4:0] src);
        if (!reset || !idValid || !uses || src == 5'd0) return 3'b000;
        for (int age = 0; age < hist.size(); age++) begin
            if (hist[age].wr && hist[age].dest == src) begin
                if (age == 0) return hist[age].load ? 3'b100 : 3'b001;
                return hist[age].load ? 3'b011 : 3'b010;
            end
        end
        return 3'b000;
    endfunction

    function automatic logic model_stall();
        logic [2:0] a;
        logic [2:0] b;
        a = model_src(idUsesRs, idRs);
        b = model_src(idUsesRt, idRt);
        return a[2] | b[2];
    endfunction

    function automatic logic [1:0] model_sel(input logic uses, input logic [4:0] src);
        logic [2:0] r;
        r = model_src(uses, src);
        return r[1:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model update on each clock edge; async reset clears it.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist.delete();
            exp_count <= 0;
        end else begin
            if (model_stall() && exp_count < CMAX) exp_count <= exp_count + 1;
            hist.push_front(entry_t'{wr:   (!(model_stall() || flush || !idValid)) && idShouldWriteRegister,
                                     dest: idRegisterWriteAddress,
                                     load: idIsLoad});
            if (hist.size() > 2) void'(hist.pop_back());
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("model_stall", {7'd0, shouldStall}, {7'd0, model_stall()});
        check("model_rs_sel", {6'd0, registerRsForwardControl}, {6'd0, model_sel(idUsesRs, idRs)});
        check("model_rt_sel", {6'd0, registerRtForwardControl}, {6'd0, model_sel(idUsesRt, idRt)});
        check("model_count", {6'd0, stallCount}, exp_count[7:0]);
    end

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic [4:0] dest, input logic ld, input logic fl);
        @(posedge clock);
        #1;
        idValid = v; idRs = rs; idRt = rt; idUsesRs = urs; idUsesRt = urt;
        idShouldWriteRegister = wr; idRegisterWriteAddress = dest; idIsLoad = ld; flush = fl;
        #1;
    endtask

    task automatic lit(input string name, input logic stall, input logic [1:0] rs_sel,
                       input logic [1:0] rt_sel);
        check({name, "_stall"}, {7'd0, shouldStall}, {7'd0, stall});
        check({name, "_rs"}, {6'd0, registerRsForwardControl}, {6'd0, rs_sel});
        check({name, "_rt"}, {6'd0, registerRtForwardControl}, {6'd0, rt_sel});
    endtask

    initial begin
        #2;
        lit("reset", 1'b0, 2'b00, 2'b00);
        check("reset_count", {6'd0, stallCount}, 8'd0);
        #10 reset = 1'b1;

        // EX then MEM ALU forwarding
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
        lit("add3", 1'b0, 2'b00, 2'b00);
        drive(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0, 0);
        lit("fwd_ex", 1'b0, 2'b01, 2'b00);
        drive(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        lit("fwd_mem", 1'b0, 2'b10, 2'b00);

        // Load-use: one stall, then load-data forward
        drive(1, 5'd2, 5'd0, 1, 0, 1, 5'd5, 1, 0);
        drive(1, 5'd0, 5'd5, 0, 1, 1, 5'd6, 0, 0);
        lit("loaduse", 1'b1, 2'b00, 2'b00);
        drive(1, 5'd0, 5'd5, 0, 1, 1, 5'd6, 0, 0);
        lit("loaduse_next", 1'b0, 2'b00, 2'b11);
        check("loaduse_count", {6'd0, stallCount}, 8'd1);

        // Register zero never matches, even against a load
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 1, 0);
        drive(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 0);
        lit("reg0", 1'b0, 2'b00, 2'b00);

        // EX ALU write beats MEM load of the same register
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 1, 0);
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0);
        drive(1, 5'd7, 5'd7, 1, 1, 0, 5'd0, 0, 0);
        lit("priority", 1'b0, 2'b01, 2'b01);

        // Flushed writer leaves nothing to match
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 0, 1);
        drive(1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        lit("flush_ex", 1'b0, 2'b00, 2'b00);
        drive(1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        lit("flush_mem", 1'b0, 2'b00, 2'b00);

        // Invalid decode does not stall on a stale EX load
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd10, 1, 0);
        drive(0, 5'd10, 5'd10, 1, 1, 0, 5'd0, 0, 0);
        lit("invalid", 1'b0, 2'b00, 2'b00);

        // Stall together with flush: single bubble, load still reaches MEM
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd11, 1, 0);
        drive(1, 5'd11, 5'd0, 1, 0, 0, 5'd0, 0, 1);
        lit("stall_flush", 1'b1, 2'b00, 2'b00);
        drive(1, 5'd11, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        lit("stall_flush_next", 1'b0, 2'b11, 2'b00);
        check("count2", {6'd0, stallCount}, 8'd2);

        // Saturation after four stall cycles
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd12, 1, 0);
        drive(1, 5'd12, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        lit("stall3", 1'b1, 2'b00, 2'b00);
        drive(1, 5'd12, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        check("count3", {6'd0, stallCount}, 8'd3);
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd13, 1, 0);
        drive(1, 5'd0, 5'd13, 0, 1, 0, 5'd0, 0, 0);
        lit("stall4", 1'b1, 2'b00, 2'b00);
        drive(1, 5'd0, 5'd13, 0, 1, 0, 5'd0, 0, 0);
        check("count_sat", {6'd0, stallCount}, 8'd3);

        // Reset mid-stall clears everything asynchronously
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd14, 1, 0);
        drive(1, 5'd14, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        lit("pre_reset", 1'b1, 2'b00, 2'b00);
        reset = 1'b0;
        #1;
        lit("async_reset", 1'b0, 2'b00, 2'b00);
        check("async_reset_count", {6'd0, stallCount}, 8'd0);
        @(posedge clock);
        #3 reset = 1'b1;
        drive(1, 5'd14, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        lit("post_reset", 1'b0, 2'b00, 2'b00);
        check("post_reset_count", {6'd0, stallCount}, 8'd0);

        @(posedge clock);
        #10;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks in-flight register writes for the 5-stage pipeline and generates the decode-stage stall (WPCIR) and operand forward selects (FWDA/FWDB). It sits beside the decode stage and keeps its own shadow copy of the EX and MEM destination-register state. It advances that state every clock, inserting bubbles when it stalls. Branches and jumps resolve in decode, so every rs/rt consumer in decode is covered.

## Interface
- `COUNTER_WIDTH`, default 16: width of the saturating stall-cycle counter.

- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low; clears all state.
- `idValid`, input, 1: decode holds a real instruction. 0 means bubble or fetch miss.
- `idRs`, input, 5: rs field of the decode instruction.
- `idRt`, input, 5: rt field of the decode instruction.
- `idUsesRs`, input, 1: decode instruction reads rs.
- `idUsesRt`, input, 1: decode instruction reads rt.
- `idShouldWriteRegister`, input, 1: WREG of the decode instruction.
- `idRegisterWriteAddress`, input, 5: final destination (rt, rd or 31).
- `idIsLoad`, input, 1: M2REG of the decode instruction.
- `flush`, input, 1: kill the instruction entering EX this cycle.
- `shouldStall`, output, 1: hold PC and IF/ID; EX receives a bubble.
- `registerRsForwardControl`, output, 2: rs source. 00 = register file, 01 = EX ALU result, 10 = MEM ALU result, 11 = MEM load data.
- `registerRtForwardControl`, output, 2: rt source, same encoding.
- `stallCount`, output, COUNTER_WIDTH: total stall cycles since reset. Saturates.

## Operation
- State consists of two entries, EX and MEM. Each entry holds {valid, write, dest[4:0], load}.
- A source is "live" when its uses bit is 1, idValid is 1, and the register is not 0.
- Match against an entry requires entry.valid & entry.write & (dest == source).
- Forward select for each live source uses EX-over-MEM priority:
  - EX match, not load → 01.
  - EX match, load → stall. The select output is don't-care; drive 00.
  - Otherwise MEM match, not load → 10.
  - Otherwise MEM match, load → 11.
  - Otherwise → 00.
- A source that is not live always selects 00. Register 0 never matches.
- shouldStall = (live rs matches an EX load) | (live rt matches an EX load).
- WB needs no forwarding: the register file is write-through (same-cycle write is visible on read).
- Every clock, MEM ← EX.
- Every clock, EX ← bubble if shouldStall | flush | !idValid; otherwise EX ← {1, idShouldWriteRegister, idRegisterWriteAddress, idIsLoad}.
- stallCount increments on each clock where shouldStall = 1. It holds at all-ones once saturated.
- flush does not suppress shouldStall. It only affects the EX entry.

## Timing
- shouldStall and both forward selects are combinational from the id* inputs and the registered EX/MEM entries. No cycle of latency.
- A load-use pair produces exactly one stall cycle:
  - Next cycle the load is in MEM and the consumer is still in decode.
  - The select becomes 11 with no stall.
- Back-to-back dependent ALU ops produce no stall, using select 01 and then 10.
- Reset values: EX.valid = 0, MEM.valid = 0, stallCount = 0.
- While reset is low: shouldStall = 0 and both selects = 00.
- Asserting reset mid-stall clears state immediately. No bubble is pending after reset is released.
- A simultaneous stall and flush inserts a single bubble.
- If the same register is written in EX and MEM, the EX (youngest) entry wins.

## Test plan
- Forward from EX: `lw $1` retired, `add $3,$1,$2` → EX, then `sub $4,$3,$1` in decode with idRs=3 → rs select 01, no stall. One cycle later, a consumer of $3 gets rs select 10.
- Load-use stall: EX = load with dest 5, decode has idRt=5 with idUsesRt → shouldStall = 1 for one cycle. The next cycle shows rt select 11, shouldStall = 0, and stallCount = 1.
- Register zero: EX = write with dest 0, decode rs = 0 → select 00, no stall.
- Priority: EX writes $7 as an ALU op and MEM loads $7, decode reads $7 → select 01, no stall.
- Flush and bubble: flush = 1 with a writing instruction in decode → the next cycle shows no match against its dest. With idValid = 0, a stale EX load match does not stall.
- Saturation and reset: with COUNTER_WIDTH = 2, four stall cycles give stallCount = 3. Pulsing reset low mid-stall clears stallCount to 0 and drives shouldStall to 0 asynchronously.
